// File: rtl/clk_period_meter_pkg.sv
// Shared constants and state encoding for the clock-period meter.
// The default width and timeout are shared with the clock divider, so its terminal count and the meter agree.
package clk_period_meter_pkg;

    localparam int DEFAULT_CNT_W   = 26;
    localparam int DEFAULT_TIMEOUT = 50_000_000;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/clk_period_meter_sync_rise_det.sv
// Brings an asynchronous slow input into the clk domain through two flops.
// Produces the synchronised level and a one-cycle pulse on each rising edge.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic s2_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign s2_o   = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Counts clk cycles between rising edges of sig_in and publishes each period with a one-cycle strobe.
// Optional macro HIGH_TIME_EN adds a high_time output that reports the cycles sig_in stayed high.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
`ifdef HIGH_TIME_EN
    output logic [CNT_W-1:0] high_time,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic rise;

`ifdef HIGH_TIME_EN
    logic s2;

    sync_rise_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .s2_o   (s2),
        .rise_o (rise)
    );
`else
    sync_rise_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .s2_o   (),
        .rise_o (rise)
    );
`endif

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!en) begin
            // Disable overrides any coincident edge; period and timeout are held.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        cnt_d     = CNT_ONE;
                        timeout_d = 1'b0;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

`ifdef HIGH_TIME_EN
    logic [CNT_W-1:0] ht_q, ht_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;

    // ht never exceeds cnt, so it is bounded by TIMEOUT and cannot wrap.
    always_comb begin
        ht_d        = ht_q;
        high_time_d = high_time_q;

        if (!en) begin
            ht_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ht_d = rise ? CNT_ONE : '0;
                end
                MEASURE: begin
                    if (rise) begin
                        high_time_d = ht_q;
                        ht_d        = CNT_ONE;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        ht_d = '0;
                    end else if (s2) begin
                        ht_d = ht_q + CNT_ONE;
                    end
                end
                default: begin
                    ht_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ht_q        <= '0;
            high_time_q <= '0;
        end else begin
            ht_q        <= ht_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with CNT_W=8, TIMEOUT=100.
// Table of square waves plus hand sequences for timeout, enable drop and async reset.
module tb_clk_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             busy;
`ifdef HIGH_TIME_EN
    logic [CNT_W-1:0] high_time;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int last_period = 0;
    bit seen_timeout = 1'b0;

    always #5 clk = ~clk;

    clk_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
`ifdef HIGH_TIME_EN
        .high_time    (high_time),
`endif
        .busy         (busy)
    );

    typedef struct {
        int per;
        int high;
        int exp_valids;
        int exp_period;
        int exp_timeout;
        int exp_high;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clk and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (period_valid === 1'b1) begin
            n_valid++;
            last_period = int'(period);
        end
        if (timeout === 1'b1) seen_timeout = 1'b1;
    endtask

    task automatic clear_mon();
        n_valid      = 0;
        last_period  = 0;
        seen_timeout = 1'b0;
    endtask

    task automatic do_reset();
        sig_in = 1'b0;
        en     = 1'b0;
        rst    = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) tick();
        clear_mon();
    endtask

    task automatic square(input int per, input int high, input int reps);
        for (int r = 0; r < reps; r++) begin
            sig_in = 1'b1;
            repeat (high) tick();
            sig_in = 1'b0;
            repeat (per - high) tick();
        end
    endtask

    // One more rising edge, held long enough for its strobe to be sampled.
    task automatic final_edge();
        sig_in = 1'b1;
        repeat (3) tick();
        sig_in = 1'b0;
        tick();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_to;

        vecs[0] = '{per: 20,  high: 10, exp_valids: 3, exp_period: 20,  exp_timeout: 0, exp_high: 10};
        vecs[1] = '{per: 30,  high: 15, exp_valids: 3, exp_period: 30,  exp_timeout: 0, exp_high: 15};
        vecs[2] = '{per: 7,   high: 3,  exp_valids: 3, exp_period: 7,   exp_timeout: 0, exp_high: 3};
        vecs[3] = '{per: 40,  high: 10, exp_valids: 3, exp_period: 40,  exp_timeout: 0, exp_high: 10};
        vecs[4] = '{per: 100, high: 50, exp_valids: 3, exp_period: 100, exp_timeout: 0, exp_high: 50};
        vecs[5] = '{per: 101, high: 50, exp_valids: 0, exp_period: 0,   exp_timeout: 1, exp_high: 0};

        // Reset state.
        sig_in = 1'b0;
        en     = 1'b0;
        rst    = 1'b1;
        tick();
        check("reset period", 32'(period), 0);
        check("reset valid", 32'(period_valid), 0);
        check("reset timeout", 32'(timeout), 0);
        check("reset busy", 32'(busy), 0);
`ifdef HIGH_TIME_EN
        check("reset high_time", 32'(high_time), 0);
`endif

        // Square waves: four rising edges each; the first only arms the measurement.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            square(vecs[v].per, vecs[v].high, 3);
            final_edge();
            check($sformatf("vec%0d valid count", v), 32'(n_valid), 32'(vecs[v].exp_valids));
            check($sformatf("vec%0d period", v), 32'(period), 32'(vecs[v].exp_period));
            check($sformatf("vec%0d timeout seen", v), 32'(seen_timeout), 32'(vecs[v].exp_timeout));
            check($sformatf("vec%0d busy", v), 32'(busy), 1);
            if (vecs[v].exp_valids > 0)
                check($sformatf("vec%0d strobed period", v), 32'(last_period), 32'(vecs[v].exp_period));
`ifdef HIGH_TIME_EN
            check($sformatf("vec%0d high_time", v), 32'(high_time), 32'(vecs[v].exp_high));
`endif
        end

        // Single edge then silence: timeout lands 100 cycles after the edge is detected.
        do_reset();
        square(20, 10, 1);
        sig_in   = 1'b1;
        first_to = 0;
        for (int i = 1; i <= 200 && first_to == 0; i++) begin
            if (i == 10) sig_in = 1'b0;
            tick();
            if (timeout === 1'b1) first_to = i;
        end
        check("timeout cycle", 32'(first_to), 103);
        check("timeout busy", 32'(busy), 0);
        check("timeout period held", 32'(period), 20);
        check("timeout valid count", 32'(n_valid), 1);

        // Recovery with a 30-cycle wave.
        clear_mon();
        square(30, 15, 2);
        final_edge();
        check("recover valid count", 32'(n_valid), 2);
        check("recover period", 32'(period), 30);
        check("recover timeout", 32'(timeout), 0);

        // Enable dropped for 5 cycles mid-period.
        do_reset();
        square(20, 10, 2);
        sig_in = 1'b1;
        repeat (5) tick();
        sig_in = 1'b0;
        repeat (3) tick();
        clear_mon();
        en = 1'b0;
        tick();
        check("en low busy", 32'(busy), 0);
        check("en low period held", 32'(period), 20);
        repeat (4) tick();
        check("en low no valid", 32'(n_valid), 0);
        en = 1'b1;
        square(24, 12, 2);
        final_edge();
        check("re-enable valid count", 32'(n_valid), 2);
        check("re-enable period", 32'(period), 24);

        // Asynchronous reset between clock edges mid-measurement.
        do_reset();
        square(20, 10, 2);
        sig_in = 1'b1;
        repeat (5) tick();
        check("pre-rst period", 32'(period), 20);
        #3;
        rst = 1'b1;
        #1;
        check("async rst period", 32'(period), 0);
        check("async rst valid", 32'(period_valid), 0);
        check("async rst timeout", 32'(timeout), 0);
        check("async rst busy", 32'(busy), 0);
`ifdef HIGH_TIME_EN
        check("async rst high_time", 32'(high_time), 0);
`endif
        sig_in = 1'b0;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        clear_mon();
        square(40, 10, 2);
        final_edge();
        check("post-rst valid count", 32'(n_valid), 2);
        check("post-rst period", 32'(period), 40);
`ifdef HIGH_TIME_EN
        check("post-rst high_time", 32'(high_time), 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
